subservient_sram_bridge: RTL
============================

Name: subservient_sram_bridge

Overview:
- Generalised SRAM front-end for the subservient SoC: one external single-port-per-direction SRAM shared between the SERV register-file interface and NUM_WB 32-bit Wishbone masters (e.g. ibus/dbus arbiter output, debug).
- Supports configurable SRAM data width.
- Serialises each 32-bit Wishbone access into 32/sram_dw SRAM beats with lane write masks.
- Gives the register file absolute priority and round-robin arbitrates the Wishbone masters.

Parameters:
- depth, 512, SRAM size in bytes (power of two).
- sram_dw, 8, SRAM data width; legal values 8, 16, 32.
- NUM_WB, 2, number of Wishbone masters (1..4).
- RF_INVERT, 1, when 1 the RF address is bitwise inverted (zero-extended first) so the RF sits at the top of SRAM.
- rfaw, 8, RF address width.
- saw, $clog2(depth*8/sram_dw), SRAM word address width (derived).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_rf_waddr  in  rfaw  RF write word address
- i_rf_wdata  in  sram_dw  RF write data
- i_rf_wen  in  1  RF write strobe
- i_rf_raddr  in  rfaw  RF read word address
- i_rf_ren  in  1  RF read strobe
- o_rf_rdata  out  sram_dw  RF read data, valid the cycle after i_rf_ren
- o_sram_waddr  out  saw  SRAM write address
- o_sram_wdata  out  sram_dw  SRAM write data
- o_sram_wmask  out  sram_dw/8  SRAM byte-lane write mask
- o_sram_wen  out  1  SRAM write enable
- o_sram_raddr  out  saw  SRAM read address (1-cycle read latency)
- i_sram_rdata  in  sram_dw  SRAM read data
- i_wb_adr  in  32*NUM_WB  packed byte addresses; master n at [32n+31:32n]
- i_wb_dat  in  32*NUM_WB  packed write data
- i_wb_sel  in  4*NUM_WB  packed byte selects
- i_wb_we  in  NUM_WB  write enables
- i_wb_stb  in  NUM_WB  strobes (classic Wishbone; held until ack)
- o_wb_rdt  out  32*NUM_WB  packed read data
- o_wb_ack  out  NUM_WB  one-cycle ack per master

Behaviour:
- Clocking: single clock i_clk; reset i_rst synchronous, active-high.
- Reset values: o_wb_ack=0, o_wb_rdt=0, o_sram_wen=0, o_sram_wmask=0, FSM=IDLE, beat counter=0, round-robin pointer=0.
- Addresses:
  - BEATS=32/sram_dw.
  - WB SRAM address = {i_wb_adr[$clog2(depth)-1:2], beat} with beat width $clog2(BEATS); for sram_dw=32, beat bits are absent.
  - RF address = RF_INVERT ? ~zext(addr) : zext(addr), to saw bits.
- RF priority:
  - If i_rf_wen: o_sram_wen=1, o_sram_wmask=all ones, waddr/wdata from RF.
  - If i_rf_ren: raddr from RF.
  - o_rf_rdata=i_sram_rdata combinationally; the RF caller samples it the cycle after ren.
  - Any cycle with i_rf_wen|i_rf_ren is an RF cycle: the WB FSM issues no beat and the beat counter holds.
- FSM:
  - IDLE:
    - If any stb is set, grant the first requester at or after the RR pointer, wrapping modulo NUM_WB.
    - Latch master index, adr, dat, sel, we. Go to XFER with beat=0.
    - Grant is taken even in an RF cycle.
  - XFER: in each non-RF cycle, issue beat k, then k++.
    - Write beat: o_sram_wen=|mask; mask=sel lanes for the beat; wdata=dat slice [k*sram_dw +: sram_dw]. A beat with mask 0 still consumes a cycle.
    - Read beat: raddr issued. i_sram_rdata is captured into slice k of the read buffer in the following cycle, regardless of RF activity in that cycle.
    - After the last beat: writes go to ACK; reads go to RDWAIT.
  - RDWAIT: capture the final slice, go to ACK.
  - ACK:
    - o_wb_ack[granted]=1 for exactly one cycle.
    - For reads, o_wb_rdt[granted] = buffer.
    - RR pointer = granted+1 (mod NUM_WB). Return to IDLE.
    - Re-arbitration is possible at the earliest in the cycle after ACK.
- Latency with no RF contention, from the grant cycle:
  - Write: ack in cycle BEATS+1.
  - Read: ack in cycle BEATS+2.
  - Each RF cycle during XFER adds one cycle.
- o_wb_rdt of a master holds its value until that master's next read ack; write acks leave it unchanged.
- Masters without a grant see no ack. A stb dropped before ack is a protocol violation; behaviour is undefined.
- Reset mid-transfer: FSM returns to IDLE, no ack is issued, no further SRAM writes occur, and the partial buffer is discarded.
- Simultaneous RF write and WB write target the same port: RF wins, and the WB beat is retried next non-RF cycle with its address and data unchanged.

Test Plan:
- sram_dw=8, master0 write adr=0x10, dat=0xA1B2C3D4, sel=0xF -> SRAM writes to 0x10..0x13 of D4,C3,B2,A1; ack at cycle 5 after grant.
- sram_dw=8, read adr=0x10 after the previous write -> o_wb_rdt=0xA1B2C3D4; ack at cycle 6 after grant.
- sram_dw=16, write sel=0x4, dat=0x00EE0000, adr=0x20 -> exactly one SRAM write: waddr=0x11, wmask=2'b01, wdata=0x00EE. Beat 0 has no wen. Ack after 3 cycles.
- NUM_WB=2, both stb asserted continuously, 3 transactions each -> grants alternate 0,1,0,1,0,1, starting with master 0 after reset.
- RF ren/wen asserted in 2 cycles during a WB read -> RF write lands at ~addr with all ones mask; WB ack is delayed by exactly 2 cycles; read data is correct.
- i_rst pulsed at beat 2 of a sram_dw=8 write -> only bytes 0-1 are written, no ack; the next transaction completes normally with RR pointer=0.

Source files
------------

// File: rtl/subservient_sram_bridge.sv
// SRAM front-end for the subservient SoC.
// One external SRAM is shared between the SERV register file and NUM_WB
// 32-bit Wishbone masters. The register file always wins the port. Each
// Wishbone access is split into 32/sram_dw SRAM beats with per-lane write
// masks. Wishbone masters are served in round-robin order.
module subservient_sram_bridge #(
    parameter int depth     = 512,
    parameter int sram_dw   = 8,
    parameter int NUM_WB    = 2,
    parameter int RF_INVERT = 1,
    parameter int rfaw      = 8,
    parameter int saw       = $clog2(depth * 8 / sram_dw)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    // register file side
    input  logic [rfaw-1:0]         i_rf_waddr,
    input  logic [sram_dw-1:0]      i_rf_wdata,
    input  logic                    i_rf_wen,
    input  logic [rfaw-1:0]         i_rf_raddr,
    input  logic                    i_rf_ren,
    output logic [sram_dw-1:0]      o_rf_rdata,
    // SRAM side
    output logic [saw-1:0]          o_sram_waddr,
    output logic [sram_dw-1:0]      o_sram_wdata,
    output logic [sram_dw/8-1:0]    o_sram_wmask,
    output logic                    o_sram_wen,
    output logic [saw-1:0]          o_sram_raddr,
    input  logic [sram_dw-1:0]      i_sram_rdata,
    // Wishbone masters, packed
    input  logic [32*NUM_WB-1:0]    i_wb_adr,
    input  logic [32*NUM_WB-1:0]    i_wb_dat,
    input  logic [4*NUM_WB-1:0]     i_wb_sel,
    input  logic [NUM_WB-1:0]       i_wb_we,
    input  logic [NUM_WB-1:0]       i_wb_stb,
    output logic [32*NUM_WB-1:0]    o_wb_rdt,
    output logic [NUM_WB-1:0]       o_wb_ack
);

    localparam int BEATS = 32 / sram_dw;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int MW    = sram_dw / 8;
    localparam int AW    = $clog2(depth);
    localparam int IW    = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER   = 2'd1,
        RDWAIT = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic [IW-1:0]           rr_q, rr_d;
    logic [IW-1:0]           gnt_q, gnt_d;

    // latched request of the granted master
    logic [AW-3:0]           adr_q;
    logic [31:0]             dat_q;
    logic [3:0]              sel_q;
    logic                    we_q;

    // read assembly: a read beat issued in one cycle is captured the next
    logic                    cap_q;
    logic [BW-1:0]           cap_beat_q;
    logic [31:0]             rbuf_q;
    logic [NUM_WB-1:0][31:0] rdt_q;
    logic [NUM_WB-1:0][31:0] rdt_view;

    logic                    rf_cyc;
    logic                    beat_go;
    logic                    last_beat;
    logic                    req_vld;
    logic [IW-1:0]           req_idx;
    logic [saw-1:0]          wb_addr;
    logic [saw-1:0]          rf_waddr_x;
    logic [saw-1:0]          rf_raddr_x;
    logic [31:0]             dat_sh;
    logic [3:0]              sel_sh;
    logic [sram_dw-1:0]      beat_wdata;
    logic [MW-1:0]           beat_wmask;

    // Any RF strobe owns the SRAM this cycle; the WB beat waits.
    assign rf_cyc    = i_rf_wen | i_rf_ren;
    assign beat_go   = (state_q == XFER) && !rf_cyc && !i_rst;
    assign last_beat = (beat_q == BW'(BEATS - 1));

    // Beat index forms the low SRAM address bits; absent for 32-bit SRAM.
    generate
        if (BEATS > 1) begin : g_beat_addr
            assign wb_addr = saw'({adr_q, beat_q});
        end else begin : g_word_addr
            assign wb_addr = saw'(adr_q);
        end
    endgenerate

    // RF sits at the top of SRAM when inverted.
    assign rf_waddr_x = (RF_INVERT != 0) ? ~saw'(i_rf_waddr) : saw'(i_rf_waddr);
    assign rf_raddr_x = (RF_INVERT != 0) ? ~saw'(i_rf_raddr) : saw'(i_rf_raddr);

    assign dat_sh     = dat_q >> (int'(beat_q) * sram_dw);
    assign sel_sh     = sel_q >> (int'(beat_q) * MW);
    assign beat_wdata = dat_sh[sram_dw-1:0];
    assign beat_wmask = sel_sh[MW-1:0];

    assign o_rf_rdata = i_sram_rdata;

    // Round-robin pick: first strobing master at or after the pointer.
    always_comb begin
        req_vld = 1'b0;
        req_idx = '0;
        for (int i = 0; i < NUM_WB; i++) begin
            if (!req_vld && i_wb_stb[(int'(rr_q) + i) % NUM_WB]) begin
                req_vld = 1'b1;
                req_idx = IW'((int'(rr_q) + i) % NUM_WB);
            end
        end
    end

    // Next-state logic for the Wishbone transfer sequencer.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    state_d = XFER;
                    beat_d  = '0;
                    gnt_d   = req_idx;
                end
            end
            XFER: begin
                if (beat_go) begin
                    if (last_beat) begin
                        state_d = we_q ? ACK : RDWAIT;
                        beat_d  = '0;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                    end
                end
            end
            RDWAIT: state_d = ACK;
            ACK: begin
                state_d = IDLE;
                rr_d    = (gnt_q == IW'(NUM_WB - 1)) ? '0 : gnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state, read buffer and per-master read data registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            rr_q       <= '0;
            gnt_q      <= '0;
            cap_q      <= 1'b0;
            cap_beat_q <= '0;
            rbuf_q     <= '0;
            rdt_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            rr_q       <= rr_d;
            gnt_q      <= gnt_d;
            cap_q      <= beat_go && !we_q;
            cap_beat_q <= beat_q;
            if (cap_q) begin
                rbuf_q[int'(cap_beat_q)*sram_dw +: sram_dw] <= i_sram_rdata;
            end
            if (state_q == ACK && !we_q) begin
                rdt_q[gnt_q] <= rbuf_q;
            end
        end
    end

    // Capture the winning master's request at grant time.
    always_ff @(posedge i_clk) begin
        if (state_q == IDLE && req_vld) begin
            adr_q <= i_wb_adr[int'(req_idx)*32 + 2 +: AW - 2];
            dat_q <= i_wb_dat[int'(req_idx)*32 +: 32];
            sel_q <= i_wb_sel[int'(req_idx)*4 +: 4];
            we_q  <= i_wb_we[req_idx];
        end
    end

    // SRAM port steering: RF first, otherwise the current WB beat.
    always_comb begin
        o_sram_wen   = 1'b0;
        o_sram_wmask = '0;
        o_sram_waddr = wb_addr;
        o_sram_wdata = beat_wdata;
        o_sram_raddr = wb_addr;
        if (!i_rst) begin
            if (i_rf_wen) begin
                o_sram_wen   = 1'b1;
                o_sram_wmask = '1;
                o_sram_waddr = rf_waddr_x;
                o_sram_wdata = i_rf_wdata;
            end else if (beat_go && we_q) begin
                o_sram_wen   = |beat_wmask;
                o_sram_wmask = beat_wmask;
            end
            if (i_rf_ren) begin
                o_sram_raddr = rf_raddr_x;
            end
        end
    end

    // Ack and read data for the granted master during the ACK cycle.
    always_comb begin
        o_wb_ack = '0;
        rdt_view = rdt_q;
        if (state_q == ACK && !i_rst) begin
            o_wb_ack[gnt_q] = 1'b1;
            if (!we_q) begin
                rdt_view[gnt_q] = rbuf_q;
            end
        end
    end

    assign o_wb_rdt = rdt_view;

    // Address bits outside the SRAM window and shifted-out mask/data bits.
    logic unused_bits;
    assign unused_bits = ^{i_wb_adr, dat_sh, sel_sh};

endmodule
